// File: rtl/l1_i_pkg.sv
// Shared state encodings and helpers for the set-associative L1 I-cache controller.
package l1_i_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/l1_i_lru.sv
// Per-set LRU age store: ages form a permutation of 0..WAYS-1, the oldest way
// (age WAYS-1) is the replacement candidate for the read set.
module l1_i_lru
    import l1_i_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int WAYS    = 2,
    localparam int WAY_W  = clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               touch_en,
    input  logic [INDEX_W-1:0] touch_set,
    input  logic [WAY_W-1:0]   touch_way,
    input  logic [INDEX_W-1:0] rd_set,
    output logic [WAY_W-1:0]   victim
);

    localparam int SETS = 1 << INDEX_W;

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] row_d [WAYS];
    logic [WAY_W-1:0] old_age;
    logic [WAYS-1:0]  is_oldest;

    // Touched way becomes youngest; only ways younger than it age by one.
    always_comb begin
        old_age = age_q[touch_set][touch_way];
        for (int w = 0; w < WAYS; w++) begin
            row_d[w] = age_q[touch_set][w];
            if (w == int'(touch_way)) begin
                row_d[w] = '0;
            end else if (age_q[touch_set][w] < old_age) begin
                row_d[w] = age_q[touch_set][w] + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_oldest
            assign is_oldest[gi] = (age_q[rd_set][gi] == WAY_W'(WAYS - 1));
        end
    endgenerate

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (is_oldest[w]) victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                age_q[touch_set][w] <= row_d[w];
            end
        end
    end

endmodule

// File: rtl/l1_i_controller_sa.sv
// N-way set-associative L1 instruction-cache controller: tag lookup, L2 refill, flush.
// Optional hit/miss counters are built when L1_I_PERF_CNT_EN is defined.
module l1_i_controller_sa
    import l1_i_pkg::*;
#(
    parameter int TAG_W   = 52,
    parameter int INDEX_W = 6,
    parameter int WAYS    = 2,
    localparam int WAY_W  = clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TAG_W-1:0]   tag,
    input  logic [INDEX_W-1:0] index,
    input  logic               read_C_L1,
    input  logic               ready_L2_L1,
    input  logic               flush,
    output logic               stall,
    output logic               hit,
    output logic [WAY_W-1:0]   way,
    output logic               refill,
    output logic               update,
    output logic               read_L1_L2,
    output logic               write_L1_L2
`ifdef L1_I_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    localparam int SETS = 1 << INDEX_W;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               flush_pend_q, flush_pend_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]   tag_arr_q [SETS][WAYS];

    logic [WAYS-1:0]    hit_vec;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   lru_victim;
    logic [WAY_W-1:0]   victim_sel;
    logic               tag_wr;
    logic               valid_clr;
    logic               touch_en;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_lookup
            assign hit_vec[gi] = valid_q[index][gi] && (tag_arr_q[index][gi] == tag);
        end
    endgenerate

    // An invalid way is always preferred over evicting a live line.
    always_comb begin
        hit_way    = '0;
        victim_sel = lru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[index][w]) victim_sel = WAY_W'(w);
        end
    end

    assign touch_en    = hit || (state_q == REFILL);
    assign write_L1_L2 = 1'b0;

    l1_i_lru #(
        .INDEX_W (INDEX_W),
        .WAYS    (WAYS)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch_en  (touch_en),
        .touch_set ((state_q == REFILL) ? index_q : index),
        .touch_way ((state_q == REFILL) ? victim_q : hit_way),
        .rd_set    (index),
        .victim    (lru_victim)
    );

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        stall        = 1'b0;
        hit          = 1'b0;
        way          = '0;
        refill       = 1'b0;
        update       = 1'b0;
        read_L1_L2   = 1'b0;
        tag_wr       = 1'b0;
        valid_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    stall   = 1'b1;
                    state_d = FLUSH;
                end else if (read_C_L1) begin
                    if (|hit_vec) begin
                        hit    = 1'b1;
                        update = 1'b1;
                        way    = hit_way;
                    end else begin
                        stall      = 1'b1;
                        read_L1_L2 = 1'b1;
                        way        = victim_sel;
                        tag_d      = tag;
                        index_d    = index;
                        victim_d   = victim_sel;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                stall      = 1'b1;
                read_L1_L2 = 1'b1;
                way        = victim_q;
                if (flush) flush_pend_d = 1'b1;
                if (ready_L2_L1) state_d = REFILL;
            end
            REFILL: begin
                stall   = 1'b1;
                refill  = 1'b1;
                update  = 1'b1;
                way     = victim_q;
                tag_wr  = 1'b1;
                state_d = (flush_pend_q || flush) ? FLUSH : IDLE;
            end
            FLUSH: begin
                stall        = 1'b1;
                update       = 1'b1;
                valid_clr    = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            index_q      <= '0;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            if (valid_clr) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (tag_wr) begin
                valid_q[index_q][victim_q] <= 1'b1;
            end
        end
    end

    // Tag contents are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (tag_wr) tag_arr_q[index_q][victim_q] <= tag_q;
    end

`ifdef L1_I_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
        if (state_q == IDLE && state_d == MISS && miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_i_controller_sa.sv
// Randomized bench for l1_i_controller_sa against a recency-timestamp cache model.
module tb_l1_i_controller_sa;
    import l1_i_pkg::*;

    localparam int TAG_W   = 52;
    localparam int INDEX_W = 6;
    localparam int WAYS    = 2;
    localparam int WAY_W   = clog2(WAYS);
    localparam int SETS    = 1 << INDEX_W;
    localparam int RV_W    = 8 + 2 * WAY_W;

    localparam logic [TAG_W-1:0] TAG_A = 52'hFF00FF00FFFFF;
    localparam logic [TAG_W-1:0] TAG_B = 52'h0000FF00FFFFF;
    localparam logic [TAG_W-1:0] TAG_C = 52'h1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [TAG_W-1:0]   tag_i = '0;
    logic [INDEX_W-1:0] index_i = '0;
    logic               read_i = 1'b0;
    logic               ready_i = 1'b0;
    logic               flush_i = 1'b0;
    logic               stall, hit, refill, update, read_L1_L2, write_L1_L2;
    logic [WAY_W-1:0]   way;
`ifdef L1_I_PERF_CNT_EN
    logic [31:0]        hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    l1_i_controller_sa #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
        .clk         (clk),
        .rst         (rst),
        .tag         (tag_i),
        .index       (index_i),
        .read_C_L1   (read_i),
        .ready_L2_L1 (ready_i),
        .flush       (flush_i),
        .stall       (stall),
        .hit         (hit),
        .way         (way),
        .refill      (refill),
        .update      (update),
        .read_L1_L2  (read_L1_L2),
        .write_L1_L2 (write_L1_L2)
`ifdef L1_I_PERF_CNT_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: a line's recency is the timestamp of its last use; LRU = oldest stamp.
    bit               m_val [SETS][WAYS];
    logic [TAG_W-1:0] m_tag [SETS][WAYS];
    longint           m_use [SETS][WAYS];
    longint           m_clock;
    int               m_hits, m_misses;

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_val[s][w] = 1'b0;
                m_use[s][w] = -longint'(w);
            end
        end
        m_clock  = 1;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic m_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
    endtask

    task automatic m_access(input logic [TAG_W-1:0] t, input int ix, output bit eh, output int ew);
        int v;
        eh = 1'b0;
        ew = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_val[ix][w] && m_tag[ix][w] == t) begin
                eh = 1'b1;
                ew = w;
            end
        end
        if (eh) begin
            m_hits++;
        end else begin
            m_misses++;
            m_hits++;
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_val[ix][w]) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < WAYS; w++) if (m_use[ix][w] < m_use[ix][v]) v = w;
            end
            ew = v;
            m_val[ix][v] = 1'b1;
            m_tag[ix][v] = t;
        end
        m_use[ix][ew] = m_clock;
        m_clock++;
    endtask

    typedef struct {
        logic h0, s0, r0, r1, rf, upd, ha, sa;
        logic [WAY_W-1:0] rw, wa;
    } res_t;

    function automatic logic [RV_W-1:0] pack_res(input res_t r);
        return {r.h0, r.s0, r.r0, r.r1, r.rf, r.upd, r.rw, r.ha, r.sa, r.wa};
    endfunction

    function automatic logic [RV_W-1:0] expect_res(input bit eh, input int ew);
        if (eh) return {1'b1, 1'b0, 4'b0000, WAY_W'(0), 1'b1, 1'b0, WAY_W'(ew)};
        return {1'b0, 1'b1, 4'b1111, WAY_W'(ew), 1'b1, 1'b0, WAY_W'(ew)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; read_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        m_flush();
    endtask

    // Drives one fetch to completion; tag/index are scrambled while stalled.
    task automatic access(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] ix,
                          input int l2_wait, output res_t r);
        tag_i = t; index_i = ix; read_i = 1'b1;
        #1;
        r.h0 = hit; r.s0 = stall; r.r0 = read_L1_L2;
        r.r1 = 1'b0; r.rf = 1'b0; r.upd = 1'b0; r.rw = '0;
        r.ha = hit; r.sa = stall; r.wa = way;
        if (!r.h0) begin
            step();
            r.r1 = read_L1_L2;
            for (int c = 0; c < l2_wait; c++) begin
                tag_i = TAG_W'({$urandom(), $urandom()});
                index_i = INDEX_W'($urandom());
                step();
                r.r1 = r.r1 & read_L1_L2;
            end
            tag_i = t; index_i = ix; ready_i = 1'b1;
            step();
            ready_i = 1'b0;
            r.rf = refill; r.upd = update; r.rw = way;
            step();
            r.ha = hit; r.sa = stall; r.wa = way;
        end
        step();
        read_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({stall, hit, refill, update, read_L1_L2, write_L1_L2, way} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=0", {stall, hit, refill, update, read_L1_L2, write_L1_L2, way});
        end
        tag_i = TAG_A; index_i = 13; read_i = 1'b1;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cold_lookup hit=%b want=0", hit);
        end
        read_i = 1'b0;
        step();
    endtask

    task automatic test_seq(input string name, input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                            input logic [TAG_W-1:0] t2, input int n);
        logic [TAG_W-1:0] tags [3];
        bit eh; int ew; res_t r;
        tags = '{t0, t1, t2};
        for (int i = 0; i < n; i++) begin
            m_access(tags[i], 13, eh, ew);
            access(tags[i], 13, 1 + i, r);
            vectors++;
            if (pack_res(r) !== expect_res(eh, ew)) begin
                miscompares++;
                $display("FAIL %s[%0d] got=%b want=%b", name, i, pack_res(r), expect_res(eh, ew));
            end
        end
    endtask

    task automatic test_flush();
        bit eh; int ew; res_t r;
        m_access(TAG_B, 0, eh, ew);
        access(TAG_B, 0, 0, r);
        vectors++;
        if (pack_res(r) !== expect_res(eh, ew)) begin
            miscompares++;
            $display("FAIL flush_fill got=%b want=%b", pack_res(r), expect_res(eh, ew));
        end
        flush_i = 1'b1;
        #1;
        vectors++;
        if ({stall, update} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_request got=%b want=10", {stall, update});
        end
        step();
        flush_i = 1'b0;
        vectors++;
        if ({stall, update, hit} !== 3'b110) begin
            miscompares++;
            $display("FAIL flush_state got=%b want=110", {stall, update, hit});
        end
        step();
        vectors++;
        if ({stall, update} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_done got=%b want=00", {stall, update});
        end
        m_flush();
        for (int i = 0; i < 2; i++) begin
            m_access((i == 0) ? TAG_B : TAG_A, (i == 0) ? 0 : 13, eh, ew);
            access((i == 0) ? TAG_B : TAG_A, (i == 0) ? 6'd0 : 6'd13, 2, r);
            vectors++;
            if (pack_res(r) !== expect_res(eh, ew) || eh) begin
                miscompares++;
                $display("FAIL flush_after[%0d] got=%b want=%b", i, pack_res(r), expect_res(1'b0, ew));
            end
        end
    endtask

    task automatic test_flush_during_miss();
        bit eh; int ew;
        logic [TAG_W-1:0] t;
        for (int sc = 0; sc < 2; sc++) begin
            t = 52'hABC0 + TAG_W'(sc);
            m_access(t, 7, eh, ew);
            tag_i = t; index_i = 7; read_i = 1'b1;
            step();
            if (sc == 0) begin
                flush_i = 1'b1;
                step();
                flush_i = 1'b0;
            end
            flush_i = (sc == 1); ready_i = 1'b1;
            step();
            flush_i = 1'b0; ready_i = 1'b0;
            vectors++;
            if ({refill, update, stall, read_L1_L2, way} !== {4'b1110, WAY_W'(ew)}) begin
                miscompares++;
                $display("FAIL fdm_refill[%0d] got=%b want=%b", sc, {refill, update, stall, read_L1_L2, way}, {4'b1110, WAY_W'(ew)});
            end
            step();
            vectors++;
            if ({refill, update, stall} !== 3'b011) begin
                miscompares++;
                $display("FAIL fdm_flush[%0d] got=%b want=011", sc, {refill, update, stall});
            end
            m_flush();
            step();
            vectors++;
            if ({hit, stall} !== 2'b01) begin
                miscompares++;
                $display("FAIL fdm_line_gone[%0d] got=%b want=01", sc, {hit, stall});
            end
            read_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_miss();
        bit eh; int ew; res_t r;
        tag_i = 52'h3_1415; index_i = 20; read_i = 1'b1;
        step();
        vectors++;
        if (read_L1_L2 !== 1'b1) begin
            miscompares++;
            $display("FAIL rmm_request read_L1_L2=%b want=1", read_L1_L2);
        end
        read_i = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({stall, hit, refill, update, read_L1_L2, way} !== '0) begin
            miscompares++;
            $display("FAIL rmm_outputs got=%b want=0", {stall, hit, refill, update, read_L1_L2, way});
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        vectors++;
        if ({refill, update, stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL rmm_late_ready got=%b want=000", {refill, update, stall});
        end
        m_reset();
        m_access(52'h3_1415, 20, eh, ew);
        access(52'h3_1415, 20, 1, r);
        vectors++;
        if (pack_res(r) !== expect_res(eh, ew)) begin
            miscompares++;
            $display("FAIL rmm_repeat got=%b want=%b", pack_res(r), expect_res(eh, ew));
        end
    endtask

    task automatic test_random();
        logic [TAG_W-1:0]   tpool [4];
        logic [INDEX_W-1:0] ipool [3];
        bit eh; int ew; res_t r;
        logic [TAG_W-1:0] t;
        logic [INDEX_W-1:0] ix;
        tpool = '{TAG_A, TAG_B, TAG_C, 52'h5A5A5};
        ipool = '{6'd0, 6'd13, 6'd63};
        do_reset();
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                pulse_flush();
            end else begin
                t  = tpool[$urandom_range(0, 3)];
                ix = ipool[$urandom_range(0, 2)];
                m_access(t, int'(ix), eh, ew);
                access(t, ix, $urandom_range(0, 3), r);
                vectors++;
                if (pack_res(r) !== expect_res(eh, ew)) begin
                    miscompares++;
                    $display("FAIL random[%0d] tag=%h idx=%0d got=%b want=%b", i, t, ix, pack_res(r), expect_res(eh, ew));
                end
            end
        end
`ifdef L1_I_PERF_CNT_EN
        vectors++;
        if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
            miscompares++;
            $display("FAIL random_counters got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses);
        end
`endif
    endtask

`ifdef L1_I_PERF_CNT_EN
    task automatic test_perf();
        bit eh; int ew; res_t r;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            m_access(52'hE, 30 + (i % 3), eh, ew);
            access(52'hE, 6'(30 + (i % 3)), 1, r);
        end
        vectors++;
        if (hit_cnt !== 32'd5 || miss_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL perf_counts got=%0d/%0d want=5/3", hit_cnt, miss_cnt);
        end
        pulse_flush();
        vectors++;
        if (hit_cnt !== 32'd5 || miss_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL perf_after_flush got=%0d/%0d want=5/3", hit_cnt, miss_cnt);
        end
        do_reset();
        vectors++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_reset got=%0d/%0d want=0/0", hit_cnt, miss_cnt);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_seq("cold_miss", TAG_A, TAG_A, TAG_A, 1);
        test_seq("second_way", TAG_B, TAG_A, TAG_B, 3);
        test_seq("lru_evict", TAG_A, TAG_C, TAG_B, 3);
        test_flush();
        test_flush_during_miss();
        test_reset_mid_miss();
        test_random();
`ifdef L1_I_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
